// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the 8-entry FIFO control path: state codes, sizes, request decode.
// Imported by the next-state logic and the control register stage.
package fifo_ctrl_pkg;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_READ     = 3'b100,
    ST_RD_ERROR = 3'b101
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_WR   = 2'b01,
    REQ_RD   = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;

  function automatic req_e decode_req(input logic wr, input logic rd);
    return req_e'({rd, wr});
  endfunction

endpackage

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state, next-count and next-pointer logic for the FIFO control stage.
// Depends only on the requests and the current count/pointers, never on the current state.
module fifo_ns
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = fifo_ctrl_pkg::DEPTH,
  parameter int AW    = fifo_ctrl_pkg::AW,
  parameter int CW    = fifo_ctrl_pkg::CW
) (
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic [CW-1:0] count_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output state_e        state_d_o,
  output logic [CW-1:0] count_d_o,
  output logic [AW-1:0] wr_addr_d_o,
  output logic [AW-1:0] rd_addr_d_o,
  output logic          wr_ok_o,
  output logic          rd_ok_o
);

  logic full;
  logic empty;

  assign full  = (count_i == CW'(DEPTH));
  assign empty = (count_i == '0);

  always_comb begin
    state_d_o   = ST_NO_OP;
    count_d_o   = count_i;
    wr_addr_d_o = wr_addr_i;
    rd_addr_d_o = rd_addr_i;
    wr_ok_o     = 1'b0;
    rd_ok_o     = 1'b0;
    case (decode_req(wr_en_i, rd_en_i))
      REQ_WR: begin
        if (!full) begin
          state_d_o   = ST_WRITE;
          count_d_o   = count_i + CW'(1);
          wr_addr_d_o = wr_addr_i + AW'(1);
          wr_ok_o     = 1'b1;
        end else begin
          state_d_o = ST_WR_ERROR;
        end
      end
      REQ_RD: begin
        if (!empty) begin
          state_d_o   = ST_READ;
          count_d_o   = count_i - CW'(1);
          rd_addr_d_o = rd_addr_i + AW'(1);
          rd_ok_o     = 1'b1;
        end else begin
          state_d_o = ST_RD_ERROR;
        end
      end
      // Simultaneous requests are dropped on purpose; idle falls through too.
      default: state_d_o = ST_NO_OP;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: holds state, occupancy and head/tail pointers; drives register-file strobes.
// Status updates at the request edge (1-cycle latency); strobes are combinational in the request cycle.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = fifo_ctrl_pkg::DEPTH,
  parameter int AW    = fifo_ctrl_pkg::AW
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  output logic [2:0]    state_o,
  output logic [3:0]    data_count_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          we_o,
  output logic          re_o,
  output logic          wr_ack_o,
  output logic          wr_err_o,
  output logic          rd_ack_o,
  output logic          rd_err_o
);

  state_e        state_q,   state_d;
  logic [3:0]    count_q,   count_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_ok;
  logic          rd_ok;

  fifo_ns #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (4)
  ) u_ns (
    .wr_en_i     (wr_en_i),
    .rd_en_i     (rd_en_i),
    .count_i     (count_q),
    .wr_addr_i   (wr_addr_q),
    .rd_addr_i   (rd_addr_q),
    .state_d_o   (state_d),
    .count_d_o   (count_d),
    .wr_addr_d_o (wr_addr_d),
    .rd_addr_d_o (rd_addr_d),
    .wr_ok_o     (wr_ok),
    .rd_ok_o     (rd_ok)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_INIT;
      count_q   <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Strobes are masked by reset so a request in the reset cycle never reaches the register file.
  assign we_o = wr_ok & reset_n_i;
  assign re_o = rd_ok & reset_n_i;

  assign state_o      = state_q;
  assign data_count_o = count_q;
  assign wr_addr_o    = wr_addr_q;
  assign rd_addr_o    = rd_addr_q;

  assign wr_ack_o = (state_q == ST_WRITE);
  assign wr_err_o = (state_q == ST_WR_ERROR);
  assign rd_ack_o = (state_q == ST_READ);
  assign rd_err_o = (state_q == ST_RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: vector table plus an alternating write/read sequence, checked through a queue.
module tb_fifo_ctrl;

  localparam logic [2:0] S_INIT  = 3'b000;
  localparam logic [2:0] S_NOP   = 3'b001;
  localparam logic [2:0] S_WR    = 3'b010;
  localparam logic [2:0] S_WRERR = 3'b011;
  localparam logic [2:0] S_RD    = 3'b100;
  localparam logic [2:0] S_RDERR = 3'b101;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       rst_n;
    logic       exp_we;
    logic       exp_re;
    logic [2:0] st;
    logic [3:0] cnt;
    logic [2:0] wa;
    logic [2:0] ra;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] state;
  logic [3:0] data_count;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic       we;
  logic       re;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  vec_t sbq[$];

  fifo_ctrl dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .wr_en_i      (wr_en),
    .rd_en_i      (rd_en),
    .state_o      (state),
    .data_count_o (data_count),
    .wr_addr_o    (wr_addr),
    .rd_addr_o    (rd_addr),
    .we_o         (we),
    .re_o         (re),
    .wr_ack_o     (wr_ack),
    .wr_err_o     (wr_err),
    .rd_ack_o     (rd_ack),
    .rd_err_o     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic rst_n,
                              input logic e_we, input logic e_re, input logic [2:0] st,
                              input int cnt, input int wa, input int ra);
    vec_t v;
    v.wr = wr; v.rd = rd; v.rst_n = rst_n;
    v.exp_we = e_we; v.exp_re = e_re; v.st = st;
    v.cnt = 4'(cnt); v.wa = 3'(wa); v.ra = 3'(ra);
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    wr_en   = v.wr;
    rd_en   = v.rd;
    reset_n = v.rst_n;
    #1;
    chk("we", idx, int'(we), int'(v.exp_we));
    chk("re", idx, int'(re), int'(v.exp_re));
    sbq.push_back(v);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", idx, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("state",      idx, int'(state),      int'(e.st));
      chk("data_count", idx, int'(data_count), int'(e.cnt));
      chk("wr_addr",    idx, int'(wr_addr),    int'(e.wa));
      chk("rd_addr",    idx, int'(rd_addr),    int'(e.ra));
      chk("wr_ack",     idx, int'(wr_ack),     int'(e.st == S_WR));
      chk("wr_err",     idx, int'(wr_err),     int'(e.st == S_WRERR));
      chk("rd_ack",     idx, int'(rd_ack),     int'(e.st == S_RD));
      chk("rd_err",     idx, int'(rd_err),     int'(e.st == S_RDERR));
    end
  endtask

  initial begin
    int wa;
    int ra;
    int cnt;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;

    // reset, then two idle cycles
    vecs.push_back(mk(0, 0, 0, 0, 0, S_INIT, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, S_NOP,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, S_NOP,  0, 0, 0));
    // fill to 8, then one write too many
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1, 0, 1, 1, 0, S_WR, i, i % 8, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, S_WRERR, 8, 0, 0));
    // drain to 0, then one read too many
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1, 1, 0, 1, S_RD, 8 - i, 0, i % 8));
    vecs.push_back(mk(0, 1, 1, 0, 0, S_RDERR, 0, 0, 0));
    // three writes, then simultaneous requests at count 3
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(1, 0, 1, 1, 0, S_WR, i, i, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, S_NOP, 3, 3, 0));
    // up to 5, then reset with a write pending
    vecs.push_back(mk(1, 0, 1, 1, 0, S_WR, 4, 4, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, S_WR, 5, 5, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, S_INIT, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // alternating write/read from empty: count toggles, pointers wrap past 7
    wa = 0; ra = 0; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        wa  = (wa + 1) % 8;
        cnt = 1;
        apply(mk(1, 0, 1, 1, 0, S_WR, cnt, wa, ra), 100 + i);
      end else begin
        ra  = (ra + 1) % 8;
        cnt = 0;
        apply(mk(0, 1, 1, 0, 1, S_RD, cnt, wa, ra), 100 + i);
      end
    end
    apply(mk(0, 0, 1, 0, 0, S_NOP, 0, wa, ra), 200);

    chk("scoreboard_drained", 999, sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control stage of the 8-entry FIFO. Samples the read/write requests each clock, keeps the occupancy count and the head/tail pointers, and drives the 3-bit operation `state` and 4-bit `data_count` consumed by `fifo_out`, which decodes `full`/`empty`. It also generates the write/read enables and addresses for the FIFO register file.

## Interface
- `DEPTH`, 8, number of entries. Fixed at 8 for this revision.
- `AW`, 3, pointer width, log2(DEPTH).
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  synchronous, active-low reset.
- `wr_en`  input  1  write request.
- `rd_en`  input  1  read request.
- `state`  output  3  registered operation code (encodings below).
- `data_count`  output  4  registered occupancy, range 0..8.
- `wr_addr`  output  AW  registered tail pointer.
- `rd_addr`  output  AW  registered head pointer.
- `we`  output  1  combinational register-file write strobe.
- `re`  output  1  combinational register-file read strobe.
- `wr_ack`, `wr_err`, `rd_ack`, `rd_err`  output  1 each  decoded from the registered `state`.

## Operation
- State encodings:
  - INIT=000
  - NO_OP=001
  - WRITE=010
  - WR_ERROR=011
  - READ=100
  - RD_ERROR=101
  - 110 and 111 are unreachable.
- Reset (`reset_n`=0 at a rising edge):
  - `state`=INIT, `data_count`=0, `wr_addr`=0, `rd_addr`=0.
  - All acks and errs are 0.
  - `we`=`re`=0 while `reset_n`=0.
- Next state is evaluated every edge with `reset_n`=1, from `wr_en`, `rd_en` and the current `data_count`. The current `state` does not affect it, and INIT has no special exit.
  - `wr_en`=1, `rd_en`=0, count<8: WRITE, count+1, `wr_addr`+1.
  - `wr_en`=1, `rd_en`=0, count=8: WR_ERROR, nothing changes.
  - `rd_en`=1, `wr_en`=0, count>0: READ, count−1, `rd_addr`+1.
  - `rd_en`=1, `wr_en`=0, count=0: RD_ERROR, nothing changes.
  - Both 0: NO_OP, nothing changes.
  - Both 1: NO_OP, nothing changes. Simultaneous requests are deliberately ignored.
- Pointers wrap modulo 8 (7 → 0). `data_count` never exceeds 8 and never goes below 0.
- Strobes:
  - `we` = `wr_en` & ~`rd_en` & (count≠8) & `reset_n`.
  - `re` = `rd_en` & ~`wr_en` & (count≠0) & `reset_n`.
- Decoded outputs:
  - `wr_ack`=(state==WRITE), `wr_err`=(state==WR_ERROR).
  - `rd_ack`=(state==READ), `rd_err`=(state==RD_ERROR).
- If an unreachable code appears in `state`, the next edge recovers normally from the inputs.

## Timing
- Requests are sampled at the rising edge. `state`, `data_count` and the pointers update at that same edge, so there is 1-cycle latency from request to status.
- `we`/`re` are asserted in the request cycle, and `wr_addr`/`rd_addr` hold the pre-increment address during that cycle. The register file writes `wr_addr` at the edge, and read data is taken from `rd_addr` at the edge.
- `full`/`empty` from `fifo_out` are valid in the cycle after the edge, derived combinationally from the registered outputs.
- Reset mid-operation: a pending request in the reset cycle is discarded, and the outputs are reset values after that edge.
- Back-to-back requests are supported every cycle, with no bubble.

## Structure
- Shared package/include `fifo_defs`: the six state encodings, `DEPTH`, `AW`, and the count width (4).
- Sub-module `fifo_ns`: purely combinational next-state, next-count and next-pointer logic.
- `fifo_ctrl` contains the registers, the strobe logic and the ack/err decode.
- `fifo_out` consumes `state` and `data_count` unchanged.

## Test plan
- Reset, then idle 2 cycles: after reset `state`=000, count=0, pointers 0. Idle cycles then give `state`=001, count=0.
- Write 8 times back-to-back: `state`=010 each cycle, count 1..8, `wr_addr` 1..7 then 0. A 9th write gives `state`=011, count stays 8, `we`=0.
- From full, read 8 times: `state`=100, count 7..0, `rd_addr` wraps to 0. A 9th read gives `state`=101, count 0, `re`=0.
- `wr_en`=`rd_en`=1 at count=3: `state`=001, count stays 3, pointers unchanged, `we`=`re`=0.
- Alternate write/read 20 times starting empty: count toggles 1/0, and both pointers wrap past 7 with no error state.
- Assert `reset_n`=0 at count=5 together with `wr_en`=1: next edge gives `state`=000, count=0, pointers 0, and the write is not performed.
